// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen shared constants: default 640x480@60 raster timing,
// sync polarity encodings and the axis-total helper.
package vga_timing_gen_pkg;

  // Sync polarity encodings
  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  // Default horizontal timing (pixels)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default vertical timing (lines)
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam bit DEF_HSYNC_POL = POL_LOW;
  localparam bit DEF_VSYNC_POL = POL_LOW;

  localparam int DEF_POS_W      = 10;
  localparam int DEF_FETCH_LEAD = 2;

  // Full period of one raster axis
  function automatic int axis_total(
    input int active,
    input int fp,
    input int sync,
    input int bp
  );
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
// Count, sync and active are registered from the next count value.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = POL_LOW,
  parameter int W      = DEF_POS_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         active,
  output logic         wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W:0]   SYNC_LO = (W+1)'(ACTIVE + FP);
  localparam logic [W:0]   SYNC_HI = (W+1)'(ACTIVE + FP + SYNC);
  localparam logic [W:0]   ACT_END = (W+1)'(ACTIVE);

  logic [W-1:0] count_q, count_d;
  logic         sync_q, sync_d;
  logic         active_q, active_d;
  logic [W-1:0] nxt;
  logic         in_sync;

  assign wrap   = (count_q == LAST);
  assign count  = count_q;
  assign sync   = sync_q;
  assign active = active_q;

  // Next count and the decodes that will describe it
  always_comb begin
    nxt      = wrap ? '0 : count_q + 1'b1;
    in_sync  = ({1'b0, nxt} >= SYNC_LO)
             && ({1'b0, nxt} < SYNC_HI);
    count_d  = count_q;
    sync_d   = sync_q;
    active_d = active_q;
    if (adv) begin
      count_d  = nxt;
      sync_d   = in_sync ? POL : ~POL;
      active_d = ({1'b0, nxt} < ACT_END);
    end
  end

  // Axis state register; reset parks on the last count
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= LAST;
      sync_q   <= ~POL;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      sync_q   <= sync_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, syncs, active flag, pulses.
// Optional look-ahead fetch outputs under VGA_FETCH_LEAD_EN.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HSYNC_POL  = DEF_HSYNC_POL,
  parameter bit VSYNC_POL  = DEF_VSYNC_POL,
  parameter int POS_W      = DEF_POS_W,
  parameter int FETCH_LEAD = DEF_FETCH_LEAD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pixEn,
  output logic [POS_W-1:0] hPos,
  output logic [POS_W-1:0] vPos,
  output logic             hsync,
  output logic             vsync,
  output logic             videoActive,
  output logic             lineStart,
  output logic             frameStart
`ifdef VGA_FETCH_LEAD_EN
  ,
  output logic [POS_W-1:0] fetchH,
  output logic [POS_W-1:0] fetchV,
  output logic             fetchActive
`endif
);

  localparam int H_TOTAL =
    axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > (1 << POS_W)) begin : g_h_range
    $error("H_TOTAL does not fit in POS_W bits");
  end
  if (V_TOTAL > (1 << POS_W)) begin : g_v_range
    $error("V_TOTAL does not fit in POS_W bits");
  end
  if (FETCH_LEAD < 0 || FETCH_LEAD >= H_TOTAL) begin : g_lead
    $error("FETCH_LEAD must lie in 0..H_TOTAL-1");
  end

  logic h_wrap, v_wrap;
  logic h_act, v_act;
  logic v_adv;

  assign v_adv = pixEn & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL),
    .W      (POS_W)
  ) u_h (
    .clk    (clk),
    .reset  (reset),
    .adv    (pixEn),
    .count  (hPos),
    .sync   (hsync),
    .active (h_act),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL),
    .W      (POS_W)
  ) u_v (
    .clk    (clk),
    .reset  (reset),
    .adv    (v_adv),
    .count  (vPos),
    .sync   (vsync),
    .active (v_act),
    .wrap   (v_wrap)
  );

  // Both axis flags are flops updated on the same edge
  assign videoActive = h_act & v_act;

  logic ls_q, ls_d;
  logic fs_q, fs_d;

  // Pulses fire on the wrapping pixel and clear on any other clk
  always_comb begin
    ls_d = pixEn & h_wrap;
    fs_d = pixEn & h_wrap & v_wrap;
  end

  // Pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign lineStart  = ls_q;
  assign frameStart = fs_q;

`ifdef VGA_FETCH_LEAD_EN
  localparam logic [POS_W:0] H_TOTAL_W  = (POS_W+1)'(H_TOTAL);
  localparam logic [POS_W:0] H_ACTIVE_W = (POS_W+1)'(H_ACTIVE);
  localparam logic [POS_W:0] V_ACTIVE_W = (POS_W+1)'(V_ACTIVE);
  localparam logic [POS_W:0] V_LAST_W   = (POS_W+1)'(V_TOTAL - 1);
  localparam logic [POS_W:0] LEAD_W     = (POS_W+1)'(FETCH_LEAD);

  // Fetch position matching the reset raster position
  localparam int FH_RST =
    (FETCH_LEAD == 0) ? H_TOTAL - 1 : FETCH_LEAD - 1;
  localparam int FV_RST =
    (FETCH_LEAD == 0) ? V_TOTAL - 1 : 0;
  localparam bit FA_RST =
    (FH_RST < H_ACTIVE) && (FV_RST < V_ACTIVE);

  logic [POS_W-1:0] fh_q, fh_d;
  logic [POS_W-1:0] fv_q, fv_d;
  logic             fa_q, fa_d;
  logic [POS_W:0]   hn, vn, fh_sum, fv_n;

  // Look-ahead of the next raster position by FETCH_LEAD pixels
  always_comb begin
    fh_d   = fh_q;
    fv_d   = fv_q;
    fa_d   = fa_q;
    hn     = '0;
    vn     = '0;
    fh_sum = '0;
    fv_n   = '0;
    if (pixEn) begin
      hn = h_wrap ? '0 : {1'b0, hPos} + 1'b1;
      vn = {1'b0, vPos};
      if (h_wrap) begin
        vn = v_wrap ? '0 : vn + 1'b1;
      end
      fh_sum = hn + LEAD_W;
      fv_n   = vn;
      if (fh_sum >= H_TOTAL_W) begin
        fh_sum = fh_sum - H_TOTAL_W;
        fv_n   = (vn == V_LAST_W) ? '0 : vn + 1'b1;
      end
      fh_d = fh_sum[POS_W-1:0];
      fv_d = fv_n[POS_W-1:0];
      fa_d = (fh_sum < H_ACTIVE_W) && (fv_n < V_ACTIVE_W);
    end
  end

  // Fetch registers, aligned with the main outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      fh_q <= POS_W'(FH_RST);
      fv_q <= POS_W'(FV_RST);
      fa_q <= FA_RST;
    end else begin
      fh_q <= fh_d;
      fv_q <= fv_d;
      fa_q <= fa_d;
    end
  end

  assign fetchH      = fh_q;
  assign fetchV      = fv_q;
  assign fetchActive = fa_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen, default
// raster plus a tiny raster for frame-level behaviour.
module tb_vga_timing_gen;

  typedef struct {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    bit hp; bit vp;
  } cfg_t;

  typedef struct {
    int h; int v;
    bit hs; bit vs; bit va; bit ls; bit fs;
  } exp_t;

  typedef struct {
    bit rst;
    int mode;
    int n;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pixEn = 1'b0;

  logic [9:0] d_hPos, d_vPos;
  logic d_hsync, d_vsync, d_va, d_ls, d_fs;
  logic [3:0] s_hPos, s_vPos;
  logic s_hsync, s_vsync, s_va, s_ls, s_fs;
`ifdef VGA_FETCH_LEAD_EN
  logic [9:0] d_fetchH, d_fetchV;
  logic d_fetchActive;
  logic [3:0] s_fetchH, s_fetchV;
  logic s_fetchActive;
`endif

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk         (clk),
    .reset       (reset),
    .pixEn       (pixEn),
    .hPos        (d_hPos),
    .vPos        (d_vPos),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .videoActive (d_va),
    .lineStart   (d_ls),
    .frameStart  (d_fs)
`ifdef VGA_FETCH_LEAD_EN
    ,
    .fetchH      (d_fetchH),
    .fetchV      (d_fetchV),
    .fetchActive (d_fetchActive)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b0),
    .POS_W (4), .FETCH_LEAD (2)
  ) dut_s (
    .clk         (clk),
    .reset       (reset),
    .pixEn       (pixEn),
    .hPos        (s_hPos),
    .vPos        (s_vPos),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .videoActive (s_va),
    .lineStart   (s_ls),
    .frameStart  (s_fs)
`ifdef VGA_FETCH_LEAD_EN
    ,
    .fetchH      (s_fetchH),
    .fetchV      (s_fetchV),
    .fetchActive (s_fetchActive)
`endif
  );

  int tests = 0;
  int fails = 0;

  cfg_t cd, cs;
  int dh, dv, sh, sv;
  exp_t q_d[$];
  exp_t q_s[$];
  vec_t vecs[6];

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Expected outputs for raster position (h,v)
  function automatic exp_t predict(input cfg_t c, input int h,
                                   input int v, input bit ls,
                                   input bit fs);
    exp_t e;
    int hs0, vs0;
    hs0 = c.ha + c.hf;
    vs0 = c.va + c.vf;
    e.h  = h;
    e.v  = v;
    e.hs = (h >= hs0 && h < hs0 + c.hs) ? c.hp : !c.hp;
    e.vs = (v >= vs0 && v < vs0 + c.vs) ? c.vp : !c.vp;
    e.va = (h < c.ha) && (v < c.va);
    e.ls = ls;
    e.fs = fs;
    return e;
  endfunction

  // Reference raster: one clk edge
  task automatic step_model(input cfg_t c, input bit rst,
                            input bit en, inout int h,
                            inout int v, output bit ls,
                            output bit fs);
    int ht, vt;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    ls = 1'b0;
    fs = 1'b0;
    if (rst) begin
      h = ht - 1;
      v = vt - 1;
    end else if (en) begin
      ls = (h == ht - 1);
      fs = ls && (v == vt - 1);
      if (ls) begin
        h = 0;
        v = (v == vt - 1) ? 0 : v + 1;
      end else begin
        h = h + 1;
      end
    end
  endtask

  task automatic chk_all(input string t, input exp_t e,
                         input logic [31:0] h,
                         input logic [31:0] v,
                         input logic hs, input logic vs,
                         input logic va, input logic ls,
                         input logic fs);
    cmp({t, ".hPos"}, h, e.h);
    cmp({t, ".vPos"}, v, e.v);
    cmp({t, ".hsync"}, 32'(hs), 32'(e.hs));
    cmp({t, ".vsync"}, 32'(vs), 32'(e.vs));
    cmp({t, ".videoActive"}, 32'(va), 32'(e.va));
    cmp({t, ".lineStart"}, 32'(ls), 32'(e.ls));
    cmp({t, ".frameStart"}, 32'(fs), 32'(e.fs));
  endtask

  // Drive one clk: predict, push, clock, pop and compare
  task automatic cycle(input bit rst, input bit en);
    bit ls, fs;
    exp_t e;
    reset = rst;
    pixEn = en;
    step_model(cd, rst, en, dh, dv, ls, fs);
    q_d.push_back(predict(cd, dh, dv, ls, fs));
    step_model(cs, rst, en, sh, sv, ls, fs);
    q_s.push_back(predict(cs, sh, sv, ls, fs));
    @(posedge clk);
    #1;
    if (q_d.size() == 0 || q_s.size() == 0) begin
      cmp("sb_empty", 32'd1, 32'd0);
    end else begin
      e = q_d.pop_front();
      chk_all("def", e, 32'(d_hPos), 32'(d_vPos),
              d_hsync, d_vsync, d_va, d_ls, d_fs);
      e = q_s.pop_front();
      chk_all("sml", e, 32'(s_hPos), 32'(s_vPos),
              s_hsync, s_vsync, s_va, s_ls, s_fs);
    end
  endtask

  initial begin
    int cnt, hmin, hmax, lsn, ls0, ls1;
    int fsn, fs0, fs1, fvh, fvv, lvh, lvv, hhi;
    bit found;

    cd = '{ha:640, hf:16, hs:96, hb:48,
           va:480, vf:10, vs:2, vb:33, hp:1'b0, vp:1'b0};
    cs = '{ha:8, hf:2, hs:3, hb:2,
           va:6, vf:1, vs:2, vb:2, hp:1'b1, vp:1'b0};
    dh = 0; dv = 0; sh = 0; sv = 0;

    // mode: 0 pixEn low, 1 pixEn high, 2 pixEn 1-of-4
    vecs[0] = '{rst:1'b1, mode:1, n:3};
    vecs[1] = '{rst:1'b0, mode:1, n:1000};
    vecs[2] = '{rst:1'b0, mode:0, n:6};
    vecs[3] = '{rst:1'b0, mode:2, n:700};
    vecs[4] = '{rst:1'b1, mode:0, n:1};
    vecs[5] = '{rst:1'b0, mode:1, n:400};

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        case (vecs[i].mode)
          0: cycle(vecs[i].rst, 1'b0);
          1: cycle(vecs[i].rst, 1'b1);
          default: cycle(vecs[i].rst, (k % 4) == 0);
        endcase
      end
    end

    // Reset values, then the first pixel wraps to (0,0)
    cycle(1'b1, 1'b1);
    cmp("rst.hPos", 32'(d_hPos), 32'd799);
    cmp("rst.vPos", 32'(d_vPos), 32'd524);
    cmp("rst.hsync", 32'(d_hsync), 32'd1);
    cmp("rst.vsync", 32'(d_vsync), 32'd1);
    cmp("rst.va", 32'(d_va), 32'd0);
    cycle(1'b0, 1'b1);
    cmp("first.hPos", 32'(d_hPos), 32'd0);
    cmp("first.vPos", 32'(d_vPos), 32'd0);
    cmp("first.va", 32'(d_va), 32'd1);
    cmp("first.ls", 32'(d_ls), 32'd1);
    cmp("first.fs", 32'(d_fs), 32'd1);
    cycle(1'b0, 1'b1);
    cmp("second.ls", 32'(d_ls), 32'd0);
    cmp("second.fs", 32'(d_fs), 32'd0);

    // Two default lines: hsync window and lineStart spacing
    cnt = 0; hmin = 9999; hmax = -1; lsn = 0; ls0 = 0; ls1 = 0;
    for (int i = 0; i < 1600; i++) begin
      cycle(1'b0, 1'b1);
      if (!d_hsync) begin
        cnt++;
        if (int'(d_hPos) < hmin) hmin = int'(d_hPos);
        if (int'(d_hPos) > hmax) hmax = int'(d_hPos);
      end
      if (d_ls) begin
        if (lsn == 0) ls0 = i;
        else ls1 = i;
        lsn++;
      end
      if (d_hPos == 10'd639)
        cmp("va@639", 32'(d_va), 32'd1);
      if (d_hPos == 10'd640)
        cmp("va@640", 32'(d_va), 32'd0);
`ifdef VGA_FETCH_LEAD_EN
      if (d_hPos == 10'd638) begin
        cmp("fetchH@638", 32'(d_fetchH), 32'd640);
        cmp("fetchA@638", 32'(d_fetchActive), 32'd0);
      end
      if (d_hPos == 10'd798 && d_vPos == 10'd0) begin
        cmp("fetchH@798", 32'(d_fetchH), 32'd0);
        cmp("fetchV@798", 32'(d_fetchV), 32'd1);
        cmp("fetchA@798", 32'(d_fetchActive), 32'd1);
      end
`endif
    end
    cmp("hsync.low_cnt", cnt, 192);
    cmp("hsync.first", hmin, 656);
    cmp("hsync.last", hmax, 751);
    cmp("ls.count", lsn, 2);
    cmp("ls.interval", ls1 - ls0, 800);

    // Small raster, two frames: vsync window and frame period
    cycle(1'b1, 1'b1);
    fsn = 0; fs0 = 0; fs1 = 0; cnt = 0; hhi = 0;
    fvh = -1; fvv = -1; lvh = -1; lvv = -1;
    for (int i = 0; i < 330; i++) begin
      cycle(1'b0, 1'b1);
      if (s_fs) begin
        if (fsn == 0) fs0 = i;
        else fs1 = i;
        fsn++;
      end
      if (s_hsync) hhi++;
      if (!s_vsync) begin
        cnt++;
        if (fvh < 0) begin
          fvh = int'(s_hPos);
          fvv = int'(s_vPos);
        end
        if (i < 165) begin
          lvh = int'(s_hPos);
          lvv = int'(s_vPos);
        end
      end
    end
    cmp("s.fs.count", fsn, 2);
    cmp("s.fs.interval", fs1 - fs0, 165);
    cmp("s.vsync.low_cnt", cnt, 60);
    cmp("s.vsync.first_h", fvh, 0);
    cmp("s.vsync.first_v", fvv, 7);
    cmp("s.vsync.last_h", lvh, 14);
    cmp("s.vsync.last_v", lvv, 8);
    cmp("s.hsync.high_cnt", hhi, 66);

    // Small raster with pixEn 1-of-4
    cycle(1'b1, 1'b1);
    fsn = 0; fs0 = 0; fs1 = 0; lsn = 0;
    for (int i = 0; i <= 1320; i++) begin
      cycle(1'b0, (i % 4) == 0);
      if (s_ls) lsn++;
      if (s_fs) begin
        if (fsn == 0) fs0 = i;
        else fs1 = i;
        fsn++;
      end
    end
    cmp("q.fs.count", fsn, 3);
    cmp("q.fs.interval", (fs1 - fs0) / 2, 660);
    cmp("q.ls.cycles", lsn, 23);

    // Reset mid-line on the default raster
    cycle(1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle(1'b0, 1'b1);
      if (d_hPos == 10'd300) found = 1'b1;
    end
    cmp("reach_h300", 32'(found), 32'd1);
    cycle(1'b1, 1'b0);
    cmp("mid.hPos", 32'(d_hPos), 32'd799);
    cmp("mid.vPos", 32'(d_vPos), 32'd524);
    cmp("mid.hsync", 32'(d_hsync), 32'd1);
    cmp("mid.va", 32'(d_va), 32'd0);
    cycle(1'b0, 1'b1);
    cmp("restart.hPos", 32'(d_hPos), 32'd0);
    cmp("restart.vPos", 32'(d_vPos), 32'd0);
    cmp("restart.fs", 32'(d_fs), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
